// File: rtl/store_size_rmw_pkg.sv
// rtl/store_size_rmw_pkg.sv - shared store-size encodings and store FSM state type
package store_size_rmw_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - merges a byte/half/word store into an old memory word
module store_lane_merge
    import store_size_rmw_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] old_word,
    output logic [31:0] merged
);

    // Little-endian lanes: byte k lives at bits [8k+7:8k].
    always_comb begin
        merged = old_word;
        case (size)
            SIZE_WORD: merged = store_data;
            SIZE_HALF: begin
                if (byte_off[1]) merged[31:16] = store_data[15:0];
                else             merged[15:0]  = store_data[15:0];
            end
            SIZE_BYTE: merged[{byte_off, 3'b000} +: 8] = store_data[7:0];
            default:   merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_size_rmw.sv
// rtl/store_size_rmw.sv - sw/sh/sb store executor with read-modify-write for sub-word stores
module store_size_rmw
    import store_size_rmw_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

    state_t      state, state_n;
    logic [1:0]  size_q, off_q;
    logic [31:0] data_q;
    logic [2:0]  cnt, cnt_n;
    logic        busy_n, done_n, mis_n, wr_n;
    logic        accept, load_word, load_merge;
    logic [31:0] merged;

    store_lane_merge u_merge (
        .size       (size_q),
        .byte_off   (off_q),
        .store_data (data_q),
        .old_word   (mem_rdata),
        .merged     (merged)
    );

    // Outputs are registered from the next-state decision so they line up with the state.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        busy_n     = busy;
        done_n     = 1'b0;
        mis_n      = misaligned;
        wr_n       = 1'b0;
        accept     = 1'b0;
        load_word  = 1'b0;
        load_merge = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    busy_n  = 1'b1;
                    mis_n   = 1'b0;
                    state_n = DONE;
                    done_n  = 1'b1;
                    case (size)
                        SIZE_WORD: begin
                            if (addr[1:0] == 2'b00) begin
                                state_n   = WRITE;
                                done_n    = 1'b0;
                                wr_n      = 1'b1;
                                load_word = 1'b1;
                            end else begin
                                mis_n = 1'b1;
                            end
                        end
                        SIZE_HALF: begin
                            if (!addr[0]) begin
                                state_n = RD_WAIT;
                                done_n  = 1'b0;
                                cnt_n   = CNT_LOAD;
                            end else begin
                                mis_n = 1'b1;
                            end
                        end
                        SIZE_BYTE: begin
                            state_n = RD_WAIT;
                            done_n  = 1'b0;
                            cnt_n   = CNT_LOAD;
                        end
                        default: mis_n = 1'b0;
                    endcase
                end
            end
            RD_WAIT: begin
                if (cnt == 3'd0) begin
                    state_n    = WRITE;
                    wr_n       = 1'b1;
                    load_merge = 1'b1;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            WRITE: begin
                state_n = DONE;
                done_n  = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            data_q     <= 32'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wr     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            mem_wr     <= wr_n;
            busy       <= busy_n;
            done       <= done_n;
            misaligned <= mis_n;
            if (accept) begin
                size_q   <= size;
                off_q    <= addr[1:0];
                data_q   <= store_data;
                mem_addr <= {addr[31:2], 2'b00};
            end
            if (load_word)  mem_wdata <= store_data;
            if (load_merge) mem_wdata <= merged;
        end
    end

endmodule

// File: tb/tb_store_size_rmw.sv
// tb/tb_store_size_rmw.sv - scoreboard bench for store_size_rmw with a word-memory reference model
module tb_store_size_rmw;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, data_i, mem_rdata;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_wr, busy, done, misaligned;

    store_size_rmw #(.MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start_i),
        .size       (size_i),
        .addr       (addr_i),
        .store_data (data_i),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .busy       (busy),
        .done       (done),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        mis;
        int          lat;
        int          issue;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem[256];
    logic [31:0] phys_mem[256];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          age = 0;
    int          wr_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns valid data only in the cycle the request's latency says it is sampled.
    always @(negedge clk) begin
        if (reset || !busy) age <= 0;
        else                age <= age + 1;
    end

    always_comb begin
        mem_rdata = 32'h5A5A_0000 | 32'(age);
        if (busy && age == LAT) mem_rdata = phys_mem[mem_addr[9:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                wr_seen = 0;
            end else begin
                if (mem_wr) begin
                    if (exp_q.size() == 0 || !exp_q[0].wr) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_wr: got mem_wr at %h want none", mem_addr);
                    end else begin
                        check("wr_addr", mem_addr, exp_q[0].addr);
                        check("wr_data", mem_wdata, exp_q[0].wdata);
                    end
                    wr_seen++;
                    phys_mem[mem_addr[9:2]] = mem_wdata;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 want 0");
                    end else begin
                        e = exp_q.pop_front();
                        check("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
                        check("wr_count", 32'(wr_seen), {31'b0, e.wr});
                        check("latency", 32'(cyc - e.issue + 1), 32'(e.lat));
                        check("busy_at_done", {31'b0, busy}, 32'd1);
                    end
                    wr_seen = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1 want 0");
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        wait_idle();
        ref_mem[a[9:2]]  = v;
        phys_mem[a[9:2]] = v;
    endtask

    task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input bit glitch);
        exp_t        e;
        logic [31:0] old, mask;
        int          sh;
        wait_idle();
        old     = ref_mem[a[9:2]];
        e.addr  = {a[31:2], 2'b00};
        e.wr    = 1'b0;
        e.mis   = 1'b0;
        e.wdata = 32'h0;
        e.lat   = 2;
        case (sz)
            2'd0: if (a[1:0] == 2'b00) begin
                e.wr = 1'b1; e.wdata = d; e.lat = 3;
            end else e.mis = 1'b1;
            2'd1: if (!a[0]) begin
                sh = a[1] ? 16 : 0;
                mask = 32'hFFFF << sh;
                e.wdata = (old & ~mask) | ((d & 32'hFFFF) << sh);
                e.wr = 1'b1; e.lat = 3 + LAT;
            end else e.mis = 1'b1;
            2'd2: begin
                sh = 8 * int'(a[1:0]);
                mask = 32'hFF << sh;
                e.wdata = (old & ~mask) | ((d & 32'hFF) << sh);
                e.wr = 1'b1; e.lat = 3 + LAT;
            end
            default: ;
        endcase
        if (e.wr) ref_mem[a[9:2]] = e.wdata;
        e.issue = cyc;
        exp_q.push_back(e);
        start_i = 1'b1; size_i = sz; addr_i = a; data_i = d;
        @(posedge clk);
        #1;
        start_i = glitch; size_i = 2'($urandom); addr_i = a ^ 32'h10; data_i = $urandom;
        @(posedge clk);
        #1;
        start_i = 1'b0; addr_i = $urandom;
        if (glitch) begin
            for (int i = 0; i < 40 && busy && !done; i++) begin
                @(posedge clk);
                #1;
            end
            if (done) begin
                start_i = 1'b1; size_i = 2'd0; addr_i = a ^ 32'h20;
                @(posedge clk);
                #1;
                start_i = 1'b0;
            end
        end
    endtask

    task automatic reset_abort(input bit in_write);
        logic [31:0] a, saved;
        a = 32'h0000_0181;
        wait_idle();
        saved = ref_mem[a[9:2]];
        issue(2'd2, a, 32'h0000_0077, 1'b0);
        if (in_write) begin
            for (int i = 0; i < 20 && !mem_wr; i++) begin
                @(posedge clk);
                #1;
            end
        end
        #1;
        reset = 1'b1;
        #1;
        check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        exp_q.delete();
        ref_mem[a[9:2]] = saved;
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset = 1'b1; start_i = 1'b0; size_i = 2'd0; addr_i = 32'h0; data_i = 32'h0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = $urandom;
            phys_mem[i] = ref_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_wr", {31'b0, mem_wr}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_misaligned", {31'b0, misaligned}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(2'd0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
        for (int k = 3; k >= 0; k--) begin
            set_word(32'h100, 32'h1122_3344);
            issue(2'd2, 32'h100 + 32'(k), 32'h0000_00AA, 1'b0);
        end
        set_word(32'h100, 32'h1122_3344);
        issue(2'd1, 32'h0000_0102, 32'h0000_BEEF, 1'b0);
        set_word(32'h100, 32'h1122_3344);
        issue(2'd1, 32'h0000_0100, 32'hFFFF_5678, 1'b0);
        issue(2'd1, 32'h0000_0101, 32'h0000_BEEF, 1'b0);
        issue(2'd0, 32'h0000_0102, 32'h1234_5678, 1'b0);
        issue(2'd3, 32'h0000_0300, 32'hCAFE_F00D, 1'b0);

        issue(2'd2, 32'h0000_0205, 32'h0000_0033, 1'b1);
        issue(2'd1, 32'h0000_0206, 32'h0000_9876, 1'b1);
        issue(2'd0, 32'h0000_0208, 32'h0BAD_CAFE, 1'b1);
        issue(2'd0, 32'h0000_0209, 32'h0BAD_CAFE, 1'b1);
        issue(2'd3, 32'h0000_0300, 32'h1111_2222, 1'b1);

        reset_abort(1'b0);
        reset_abort(1'b1);
        issue(2'd2, 32'h0000_0181, 32'h0000_0077, 1'b0);

        repeat (80) begin
            issue(2'($urandom), $urandom, $urandom, $urandom_range(0, 3) == 0);
        end

        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        check("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
